// File: rtl/sr_pkg.sv
// ============================================================================
// sr_pkg -- shared encodings and FSM states for the SR command driver. Rev 1.0
// ============================================================================
`default_nettype none

package sr_pkg;

  // Flop pin encodings, {s, r}
  localparam logic [1:0] PIN_HOLD    = 2'b00;
  localparam logic [1:0] PIN_RESET   = 2'b01;
  localparam logic [1:0] PIN_SET     = 2'b10;
  localparam logic [1:0] PIN_INVALID = 2'b11;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RESET  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_PULSE  = 3'd4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_DRIVE      = 2'd1;
  localparam state_t ST_PULSE_HOLD = 2'd2;
  localparam state_t ST_PULSE_CLR  = 2'd3;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_PULSE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_pulse_timer.sv
// ============================================================================
// sr_pulse_timer -- loadable down-counter timing the PULSE hold phase. Rev 1.0
// ============================================================================
`default_nettype none

module sr_pulse_timer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [LEN_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - LEN_W'(1);
    end
  end

  // Last hold cycle is the one where the count reads 1.
  assign done = (count == LEN_W'(1));

endmodule

`default_nettype wire

// File: rtl/sr_cmd_driver.sv
// ============================================================================
// sr_cmd_driver -- SET/RESET/TOGGLE/PULSE strobe driver for an SR flop bank.
// Optional: SR_FB_CHECK_EN adds q_fb feedback compare and sticky fb_err. Rev 1.0
// ============================================================================
`default_nettype none

module sr_cmd_driver
  import sr_pkg::*;
#(
  parameter int N     = 8,
  parameter int CH_W  = (N > 1) ? $clog2(N) : 1,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [LEN_W-1:0] pulse_len,
  output logic [N-1:0]     s_o,
  output logic [N-1:0]     r_o,
  output logic [N-1:0]     shadow_q,
  output logic             busy,
  output logic             cmd_err,
`ifdef SR_FB_CHECK_EN
  input  logic [N-1:0]     q_fb,
`endif
  output logic             fb_err
);

  state_t           state;
  state_t           state_nx;
  logic [2:0]       op_q;
  logic [CH_W-1:0]  ch_q;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             cmd_bad;
  logic [1:0]       pin_nx;
  logic [CH_W-1:0]  strobe_ch;
  logic [N-1:0]     one_hot;
  logic             tmr_done;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_bad   = !op_legal(cmd_op) || (int'(cmd_ch) >= N);

  sr_pulse_timer #(.LEN_W(LEN_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_DRIVE && op_q == OP_PULSE && len_q != '0),
    .load_val (len_q),
    .dec      (state == ST_PULSE_HOLD),
    .done     (tmr_done)
  );

  // Strobes are decided one edge early so s_o/r_o come straight from flops.
  always_comb begin
    state_nx  = state;
    pin_nx    = PIN_HOLD;
    strobe_ch = ch_q;
    case (state)
      ST_IDLE: begin
        if (accept && !cmd_bad && cmd_op != OP_NOP) begin
          state_nx  = ST_DRIVE;
          strobe_ch = cmd_ch;
          case (cmd_op)
            OP_RESET:  pin_nx = PIN_RESET;
            OP_TOGGLE: pin_nx = shadow_q[cmd_ch] ? PIN_RESET : PIN_SET;
            default:   pin_nx = PIN_SET;
          endcase
        end
      end
      ST_DRIVE: begin
        if (op_q != OP_PULSE) begin
          state_nx = ST_IDLE;
        end else if (len_q != '0) begin
          state_nx = ST_PULSE_HOLD;
        end else begin
          state_nx = ST_PULSE_CLR;
          pin_nx   = PIN_RESET;
        end
      end
      ST_PULSE_HOLD: begin
        if (tmr_done) begin
          state_nx = ST_PULSE_CLR;
          pin_nx   = PIN_RESET;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (pin_nx == PIN_INVALID) pin_nx = PIN_HOLD;
  end

  always_comb begin
    one_hot            = '0;
    one_hot[strobe_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      s_o      <= '0;
      r_o      <= '0;
      shadow_q <= '0;
      cmd_err  <= 1'b0;
      op_q     <= OP_NOP;
      ch_q     <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_nx;
      s_o      <= pin_nx[1] ? one_hot : '0;
      r_o      <= pin_nx[0] ? one_hot : '0;
      // Shadow follows the flops: both see the same strobe on the same edge.
      shadow_q <= (shadow_q | s_o) & ~r_o;
      cmd_err  <= accept & cmd_bad;
      if (accept) begin
        op_q  <= cmd_op;
        ch_q  <= cmd_ch;
        len_q <= pulse_len;
      end
    end
  end

`ifdef SR_FB_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_err <= 1'b0;
    end else if (state == ST_IDLE && q_fb != shadow_q) begin
      fb_err <= 1'b1;
    end
  end
`else
  assign fb_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_driver.sv
// ============================================================================
// tb_sr_cmd_driver -- vector-table bench for sr_cmd_driver with an SR flop model.
// Optional: SR_FB_CHECK_EN exercises q_fb / fb_err. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sr_cmd_driver;

  // N=6 so that an out-of-range channel (6, 7) fits in the 3-bit cmd_ch.
  localparam int N     = 6;
  localparam int CH_W  = 3;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [CH_W-1:0]  cmd_ch = '0;
  logic [LEN_W-1:0] pulse_len = '0;
  logic [N-1:0]     s_o, r_o, shadow_q;
  logic             busy, cmd_err, fb_err;
  logic [N-1:0]     q_model;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef SR_FB_CHECK_EN
  logic [N-1:0] fb_inj = '0;
  logic [N-1:0] q_fb;
  assign q_fb = q_model ^ fb_inj;
`endif

  sr_cmd_driver #(.N(N), .CH_W(CH_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .pulse_len (pulse_len),
    .s_o       (s_o),
    .r_o       (r_o),
    .shadow_q  (shadow_q),
    .busy      (busy),
    .cmd_err   (cmd_err),
`ifdef SR_FB_CHECK_EN
    .q_fb      (q_fb),
`endif
    .fb_err    (fb_err)
  );

  // Behavioural SR flop bank driven by the DUT strobes.
  always @(posedge clk) begin
    for (int b = 0; b < N; b++) begin
      if (rst)                          q_model[b] <= 1'b0;
      else if (s_o[b] && !r_o[b])       q_model[b] <= 1'b1;
      else if (r_o[b] && !s_o[b])       q_model[b] <= 1'b0;
      else if (s_o[b] && r_o[b])        q_model[b] <= 1'bx;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_s_and_r", 32'(s_o & r_o), 32'd0);
      chk("inv_onehot", 32'($countones(s_o | r_o) <= 1), 32'd1);
    end
  end

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] op;
    logic [2:0] ch;
    logic [7:0] len;
    logic [5:0] s;
    logic [5:0] r;
    logic [5:0] sh;
    logic       ready;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[16];
  int   nt = 0;

  function automatic void add(input int rs, input int v, input int op, input int ch,
                              input int s, input int r, input int sh,
                              input int rdy, input int bsy, input int err);
    tbl[nt] = {1'(rs), 1'(v), 3'(op), 3'(ch), 8'd0, 6'(s), 6'(r), 6'(sh),
               1'(rdy), 1'(bsy), 1'(err)};
    nt++;
  endfunction

  task automatic run_pulse(input int ch, input int len);
    int         qhigh;
    logic [5:0] bm;
    logic [5:0] sh0;
    qhigh     = 0;
    bm        = 6'(1) << ch;
    sh0       = shadow_q;
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_ch    = 3'(ch);
    pulse_len = 8'(len);
    for (int k = 0; k <= len + 2; k++) begin
      tick();
      cmd_valid = 1'b0;
      chk("pulse_s", 32'(s_o), 32'((k == 0) ? bm : 6'd0));
      chk("pulse_r", 32'(r_o), 32'((k == len + 1) ? bm : 6'd0));
      chk("pulse_busy", 32'(busy), 32'(k <= len + 1));
      if (q_model[ch] === 1'b1) qhigh++;
    end
    chk("pulse_q_high_cycles", 32'(qhigh), 32'(len + 1));
    chk("pulse_shadow_after", 32'(shadow_q), 32'(sh0 & ~bm));
  endtask

  initial begin
    //   rst v op ch   s     r     sh   rdy bsy err
    add(1, 0, 0, 0,  0,    0,    0,    1, 0, 0);  // reset
    add(0, 1, 2, 3,  8'h08, 0,   0,    0, 1, 0);  // SET ch3
    add(0, 0, 0, 0,  0,    0,    8'h08, 1, 0, 0);
    add(0, 1, 3, 3,  0,    8'h08, 8'h08, 0, 1, 0); // TOGGLE -> r
    add(0, 0, 0, 0,  0,    0,    0,    1, 0, 0);
    add(0, 1, 3, 3,  8'h08, 0,   0,    0, 1, 0);  // TOGGLE -> s
    add(0, 0, 0, 0,  0,    0,    8'h08, 1, 0, 0);
    add(0, 1, 6, 0,  0,    0,    8'h08, 1, 0, 1); // illegal op
    add(0, 0, 0, 0,  0,    0,    8'h08, 1, 0, 0);
    add(0, 1, 2, 6,  0,    0,    8'h08, 1, 0, 1); // channel out of range
    add(0, 1, 0, 1,  0,    0,    8'h08, 1, 0, 0); // NOP
    add(0, 1, 1, 3,  0,    8'h08, 8'h08, 0, 1, 0); // RESET ch3
    add(0, 1, 2, 5,  0,    0,    0,    1, 0, 0);  // held while busy: ignored
    add(0, 1, 2, 5,  8'h20, 0,   0,    0, 1, 0);  // now accepted
    add(0, 0, 0, 0,  0,    0,    8'h20, 1, 0, 0);
    add(0, 1, 7, 7,  0,    0,    8'h20, 1, 0, 1); // illegal op + channel

    for (int i = 0; i < nt; i++) begin
      rst       = tbl[i].rst;
      cmd_valid = tbl[i].valid;
      cmd_op    = tbl[i].op;
      cmd_ch    = tbl[i].ch;
      pulse_len = tbl[i].len;
      tick();
      chk($sformatf("v%0d_s_o", i), 32'(s_o), 32'(tbl[i].s));
      chk($sformatf("v%0d_r_o", i), 32'(r_o), 32'(tbl[i].r));
      chk($sformatf("v%0d_shadow", i), 32'(shadow_q), 32'(tbl[i].sh));
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].ready));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_cmd_err", i), 32'(cmd_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_shadow_vs_flops", i), 32'(shadow_q), 32'(q_model));
    end
    cmd_valid = 1'b0;
    tick();
    chk("err_one_cycle", 32'(cmd_err), 32'd0);

    run_pulse(0, 3);
    run_pulse(0, 0);
    run_pulse(4, 1);

    // Reset in the middle of a PULSE (ch2, len 5).
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_ch = 3'd2; pulse_len = 8'd5;
    tick();
    cmd_valid = 1'b0;
    chk("rstpulse_s", 32'(s_o), 32'h04);
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rstpulse_s_after", 32'(s_o), 32'd0);
    chk("rstpulse_r_after", 32'(r_o), 32'd0);
    chk("rstpulse_shadow", 32'(shadow_q), 32'd0);
    chk("rstpulse_busy", 32'(busy), 32'd0);
    chk("rstpulse_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rstpulse_no_late_strobe", 32'(s_o | r_o), 32'd0);
    end

`ifdef SR_FB_CHECK_EN
    chk("fb_err_clean", 32'(fb_err), 32'd0);
    fb_inj = 6'h02;
    tick(); tick();
    chk("fb_err_set", 32'(fb_err), 32'd1);
    fb_inj = '0;
    tick(); tick();
    chk("fb_err_sticky", 32'(fb_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("fb_err_cleared_by_rst", 32'(fb_err), 32'd0);
`else
    chk("fb_err_tied_low", 32'(fb_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

`ifndef SR_FB_CHECK_EN
  always @(negedge clk) begin
    if (fb_err !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL fb_err_nonzero: got %b, expected 0", fb_err);
    end
  end
`endif

endmodule

`default_nettype wire
